magic_cfg_loader: RTL and testbench
===================================

// Module: magic_cfg_loader
// PURPOSE
//  Initiator side of the magic config register interface. After reset (or on start) it reads
//  a saved settings image from an external SPI EEPROM (25xx family, mode 0). It then replays
//  the image as single-cycle write strobes (cfg_wr/cfg_addr/cfg_data) into the config register
//  file, the same register map that CPU OUTs to port xxFF write in magic mode (addr = A[15:8]).
//  busy holds the machine off until the restore finishes.
// PARAMETERS
//  SPI_DIV    2       SCK half-period in clk28 cycles (>=1); SCK = 28MHz/(2*SPI_DIV)
//  NREGS      12      config registers restored, cfg_addr 8'h01..NREGS (1..254)
//  BASE_ADDR  16'h0   EEPROM byte address of the image (signature byte first)
//  SIGNATURE  8'h5A   required first image byte; any other value aborts the restore
// PORTS
//  clk28     in   1  system clock
//  rst_n     in   1  async active-low reset
//  start     in   1  re-run request; sampled only in IDLE/DONE/FAIL, single-cycle pulse
//  spi_sck   out  1  EEPROM clock, idle low
//  spi_cs_n  out  1  EEPROM chip select, idle high
//  spi_mosi  out  1  EEPROM data in; changes on SCK fall, MSB first
//  spi_miso  in   1  EEPROM data out; sampled on SCK rise, MSB first
//  cfg_wr    out  1  one-clk28 write strobe to the config register file
//  cfg_addr  out  8  config register index (8'h01..NREGS)
//  cfg_data  out  8  value to write
//  busy      out  1  high while a restore is in progress
//  valid     out  1  high after a restore with a matching signature; cleared when a restore starts
// BEHAVIOUR
//  Reset values: spi_sck=0, spi_cs_n=1, spi_mosi=0, cfg_wr=0, cfg_addr=0, cfg_data=0, busy=1,
//   valid=0, FSM=START.
//  States: START -> CMD -> ADDR -> SIG -> DATA -> GAP -> DONE | FAIL; START also re-entered
//   from DONE/FAIL on start=1.
//  START: cs_n<=0 on the first clk28 after reset release. busy=1 and valid=0 from this cycle.
//  CMD: shift 8'h03 out. ADDR: shift BASE_ADDR[15:0] out (24 SCK rises total, CS held low).
//  SIG: shift 8 bits in.
//   - byte==SIGNATURE -> DATA, idx=1.
//   - byte!=SIGNATURE -> GAP, then FAIL (no cfg_wr ever issued).
//  DATA: each 8th SCK rise completes byte b. The next clk28 drives cfg_wr=1, cfg_addr=idx,
//   cfg_data=b for exactly one cycle. Exception: b==8'hFF (erased cell) -> no strobe, register
//   keeps its default. idx increments either way; after idx==NREGS -> GAP.
//  GAP: SCK low, cs_n=1 held for 2*SPI_DIV clk28 cycles, then DONE (or FAIL).
//  DONE: busy=0, valid=1. FAIL: busy=0, valid=0.
//  SCK timing:
//   - each half-phase lasts SPI_DIV clk28 cycles
//   - first rise occurs >= SPI_DIV cycles after cs_n falls
//   - SCK never toggles while cs_n=1
//  Strobe spacing: strobes are >= 16*SPI_DIV cycles apart, so no back-pressure is needed.
//  start while busy is ignored. No spurious SCK edge on any state transition.
//  Async reset mid-transfer:
//   - cs_n goes high and SCK low immediately; strobes stop
//   - after release the whole sequence restarts from START
//  Bit/byte counters are sized for NREGS; idx never exceeds NREGS, no wrap.
// TESTING
//  1 SPI_DIV=2, EEPROM model image 5A,01..0C -> MOSI 03 00 00; exactly 12 strobes
//    (addr k, data k); strobes 32 clk apart; valid=1, busy=0.
//  2 Image 5A,03,FF,07,... -> no strobe for addr 02; addr 01=03, addr 03=07; valid=1.
//  3 Image A5,... -> 8 data SCKs after the address, zero strobes, cs_n high; valid=0, busy=0 (FAIL).
//  4 rst_n low during 5th data byte -> cs_n=1 and sck=0 within reset; after release the full
//    sequence replays 12 strobes.
//  5 start pulsed mid-restore -> ignored; start pulsed in DONE -> valid drops, busy rises,
//    second identical replay.
//  6 SPI_DIV=1, NREGS=1 -> SCK 14 MHz, one strobe addr 01; CS high gap >= 2 clk before DONE.

Source files
------------

// File: rtl/magic_cfg_loader.sv
// Boot-time restore of the magic config register file from a 25xx SPI EEPROM image.
// Reads signature + NREGS bytes and replays each one as a single-cycle config write strobe.
module magic_cfg_loader #(
  parameter int unsigned SPI_DIV   = 2,
  parameter int unsigned NREGS     = 12,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  SIGNATURE = 8'h5A
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       start,
  output logic       spi_sck,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       cfg_wr,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       busy,
  output logic       valid
);

  localparam int unsigned     CNT_W     = $clog2(2 * SPI_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SPI_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * SPI_DIV - 1);
  localparam logic [7:0]       LAST_IDX  = 8'(NREGS);
  localparam logic [23:0]      HDR       = {8'h03, BASE_ADDR};

  typedef enum logic [2:0] {
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_SIG,
    ST_DATA,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick;
  logic [2:0]       bit_cnt;
  logic             byte_end;
  logic             addr_lo;
  logic [22:0]      tx_shift;
  logic [7:0]       rx_shift;
  logic [7:0]       idx;
  logic             strobe_pend;
  logic             last_byte;
  logic             sig_ok;

  // A byte completes on its 8th SCK rise; the strobe follows one clk28 later, and any
  // state change waits for the matching fall so SCK always returns low cleanly.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_START;
      tick        <= '0;
      bit_cnt     <= '0;
      byte_end    <= 1'b0;
      addr_lo     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      idx         <= 8'd1;
      strobe_pend <= 1'b0;
      last_byte   <= 1'b0;
      sig_ok      <= 1'b0;
      spi_sck     <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_mosi    <= 1'b0;
      cfg_wr      <= 1'b0;
      cfg_addr    <= '0;
      cfg_data    <= '0;
      busy        <= 1'b1;
      valid       <= 1'b0;
    end else begin
      cfg_wr <= 1'b0;
      if (strobe_pend) begin
        strobe_pend <= 1'b0;
        if (rx_shift != 8'hFF) begin
          cfg_wr   <= 1'b1;
          cfg_addr <= idx;
          cfg_data <= rx_shift;
        end
        if (idx != LAST_IDX) idx <= idx + 8'd1;
      end

      case (state)
        ST_START: begin
          spi_cs_n  <= 1'b0;
          spi_sck   <= 1'b0;
          spi_mosi  <= HDR[23];
          tx_shift  <= HDR[22:0];
          tick      <= '0;
          bit_cnt   <= '0;
          byte_end  <= 1'b0;
          addr_lo   <= 1'b0;
          sig_ok    <= 1'b0;
          last_byte <= 1'b0;
          idx       <= 8'd1;
          busy      <= 1'b1;
          valid     <= 1'b0;
          state     <= ST_CMD;
        end

        ST_CMD, ST_ADDR, ST_SIG, ST_DATA: begin
          if (tick != HALF_LAST) begin
            tick <= tick + 1'b1;
          end else begin
            tick <= '0;
            if (!spi_sck) begin
              spi_sck  <= 1'b1;
              rx_shift <= {rx_shift[6:0], spi_miso};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_end <= 1'b1;
                if (state == ST_DATA) begin
                  strobe_pend <= 1'b1;
                  last_byte   <= (idx == LAST_IDX);
                end
              end
            end else begin
              spi_sck  <= 1'b0;
              spi_mosi <= tx_shift[22];
              tx_shift <= {tx_shift[21:0], 1'b0};
              if (byte_end) begin
                byte_end <= 1'b0;
                case (state)
                  ST_CMD:  state <= ST_ADDR;
                  ST_ADDR: begin
                    if (addr_lo) state <= ST_SIG;
                    else addr_lo <= 1'b1;
                  end
                  ST_SIG: begin
                    if (rx_shift == SIGNATURE) begin
                      sig_ok <= 1'b1;
                      idx    <= 8'd1;
                      state  <= ST_DATA;
                    end else begin
                      spi_cs_n <= 1'b1;
                      state    <= ST_GAP;
                    end
                  end
                  ST_DATA: begin
                    if (last_byte) begin
                      spi_cs_n <= 1'b1;
                      state    <= ST_GAP;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end

        ST_GAP: begin
          if (tick == GAP_LAST) begin
            busy  <= 1'b0;
            valid <= sig_ok;
            state <= sig_ok ? ST_DONE : ST_FAIL;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        ST_DONE, ST_FAIL: begin
          if (start) begin
            busy  <= 1'b1;
            valid <= 1'b0;
            state <= ST_START;
          end
        end

        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_magic_cfg_loader.sv
// Bench for magic_cfg_loader: behavioural 25xx EEPROM plus a strobe scoreboard.
// dut_a runs SPI_DIV=2/NREGS=12, dut_b runs SPI_DIV=1/NREGS=1 on the same EEPROM model.
module tb_magic_cfg_loader;

  logic clk28;
  logic rst_a_n, rst_b_n, start, miso, use_b;
  logic sck_a, cs_a, mosi_a, wr_a, busy_a, valid_a;
  logic sck_b, cs_b, mosi_b, wr_b, busy_b, valid_b;
  logic [7:0] addr_a, data_a, addr_b, data_b;

  int n_checks = 0;
  int n_fail = 0;

  magic_cfg_loader #(.SPI_DIV(2), .NREGS(12)) dut_a (
    .clk28(clk28), .rst_n(rst_a_n), .start(start),
    .spi_sck(sck_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a), .spi_miso(miso),
    .cfg_wr(wr_a), .cfg_addr(addr_a), .cfg_data(data_a),
    .busy(busy_a), .valid(valid_a)
  );

  magic_cfg_loader #(.SPI_DIV(1), .NREGS(1)) dut_b (
    .clk28(clk28), .rst_n(rst_b_n), .start(start),
    .spi_sck(sck_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b), .spi_miso(miso),
    .cfg_wr(wr_b), .cfg_addr(addr_b), .cfg_data(data_b),
    .busy(busy_b), .valid(valid_b)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  wire m_sck  = use_b ? sck_b  : sck_a;
  wire m_cs_n = use_b ? cs_b   : cs_a;
  wire m_mosi = use_b ? mosi_b : mosi_a;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // EEPROM model: 24-bit read header in, data shifted out on SCK falls.
  logic [7:0]  mem [256];
  logic [23:0] hdr;
  logic [7:0]  ea;
  int          rise_cnt = 0;
  int          last_rises = 0;
  int          off;

  always @(negedge m_cs_n) rise_cnt = 0;
  always @(posedge m_cs_n) last_rises = rise_cnt;

  always @(posedge m_sck) begin
    if (!m_cs_n) begin
      if (rise_cnt < 24) hdr = {hdr[22:0], m_mosi};
      rise_cnt++;
      if (rise_cnt == 24) checkOutput("mosi_header", {8'h0, hdr}, 32'h030000);
    end
  end

  always @(negedge m_sck) begin
    if (!m_cs_n && rise_cnt >= 24) begin
      off  = rise_cnt - 24;
      ea   = hdr[7:0] + 8'(off / 8);
      miso = mem[ea][7 - (off % 8)];
    end
  end

  // Scoreboard of expected {addr, data} strobes.
  logic [15:0] exp_q[$];
  logic [15:0] mon_obs;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_strobe_cyc = 0;
  bit spacing_on = 1'b0;

  always @(posedge clk28) cyc++;

  always @(negedge clk28) begin
    if (use_b ? wr_b : wr_a) begin
      strobe_cnt++;
      mon_obs = use_b ? {addr_b, data_b} : {addr_a, data_a};
      if (exp_q.size() > 0) checkOutput("strobe", {16'h0, mon_obs}, {16'h0, exp_q.pop_front()});
      if (spacing_on && strobe_cnt > 1) checkOutput("strobe_spacing", cyc - last_strobe_cyc, 32);
      last_strobe_cyc = cyc;
    end
  end

  // SCK rise-to-rise interval and CS-high gap of dut_b.
  time last_rise_t = 0;
  time min_iv = 1000000;
  time max_iv = 0;
  time t_cs_b = 0;
  time t_busy_b = 0;
  bit  have_rise_b = 1'b0;

  always @(negedge cs_b) have_rise_b = 1'b0;
  always @(posedge cs_b) t_cs_b = $time;
  always @(negedge busy_b) t_busy_b = $time;
  always @(posedge sck_b) begin
    if (have_rise_b) begin
      if ($time - last_rise_t < min_iv) min_iv = $time - last_rise_t;
      if ($time - last_rise_t > max_iv) max_iv = $time - last_rise_t;
    end
    have_rise_b = 1'b1;
    last_rise_t = $time;
  end

  task automatic applyStimulus(input logic [7:0] sig, input int nregs);
    mem[0] = sig;
    exp_q.delete();
    strobe_cnt = 0;
    if (sig == 8'h5A)
      for (int k = 1; k <= nregs; k++)
        if (mem[k] != 8'hFF) exp_q.push_back({8'(k), mem[k]});
  endtask

  task automatic pulseStart();
    @(negedge clk28) start = 1'b1;
    @(negedge clk28) start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk28);
      if (!(use_b ? busy_b : busy_a)) break;
    end
    checkOutput("done_in_time", {31'h0, use_b ? busy_b : busy_a}, 0);
  endtask

  task automatic waitStrobes(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk28);
      if (strobe_cnt >= n) break;
    end
    checkOutput("strobes_reached", {31'h0, strobe_cnt >= n}, 1);
  endtask

  task automatic checkEnd(input int n_exp, input logic exp_valid);
    checkOutput("strobe_count", strobe_cnt, n_exp);
    checkOutput("queue_left", exp_q.size(), 0);
    checkOutput("valid", {31'h0, use_b ? valid_b : valid_a}, {31'h0, exp_valid});
    checkOutput("cs_n_idle", {31'h0, use_b ? cs_b : cs_a}, 1);
    checkOutput("sck_idle", {31'h0, use_b ? sck_b : sck_a}, 0);
  endtask

  initial begin
    use_b = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0; start = 1'b0; miso = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = 8'hFF;
    for (int k = 1; k <= 12; k++) mem[k] = 8'(k);
    repeat (3) @(negedge clk28);

    checkOutput("rst_cs_n", {31'h0, cs_a}, 1);
    checkOutput("rst_sck", {31'h0, sck_a}, 0);
    checkOutput("rst_mosi", {31'h0, mosi_a}, 0);
    checkOutput("rst_cfg", {15'h0, wr_a, addr_a, data_a}, 0);
    checkOutput("rst_busy_valid", {30'h0, busy_a, valid_a}, 32'h2);

    $display("[TB] test 1: plain image 5A,01..0C");
    applyStimulus(8'h5A, 12);
    spacing_on = 1'b1;
    rst_a_n = 1'b1;
    @(negedge clk28);
    checkOutput("cs_fall_after_reset", {31'h0, cs_a}, 0);
    waitDone(2000);
    spacing_on = 1'b0;
    checkEnd(12, 1'b1);

    $display("[TB] test 2: erased cell skipped");
    mem[1] = 8'h03; mem[2] = 8'hFF; mem[3] = 8'h07;
    applyStimulus(8'h5A, 12);
    pulseStart();
    waitDone(2000);
    checkEnd(11, 1'b1);

    $display("[TB] test 3: bad signature");
    applyStimulus(8'hA5, 12);
    pulseStart();
    waitDone(2000);
    checkEnd(0, 1'b0);
    checkOutput("sig_sck_rises", last_rises, 32);

    $display("[TB] test 4: reset during 5th data byte");
    for (int k = 1; k <= 12; k++) mem[k] = 8'(k + 8'h40);
    applyStimulus(8'h5A, 12);
    pulseStart();
    waitStrobes(4, 2000);
    repeat (12) @(negedge clk28);
    rst_a_n = 1'b0;
    #1;
    checkOutput("mid_rst_cs_n", {31'h0, cs_a}, 1);
    checkOutput("mid_rst_sck", {31'h0, sck_a}, 0);
    checkOutput("mid_rst_busy", {31'h0, busy_a}, 1);
    applyStimulus(8'h5A, 12);
    repeat (2) @(negedge clk28);
    rst_a_n = 1'b1;
    waitDone(2000);
    checkEnd(12, 1'b1);

    $display("[TB] test 5: start while busy, then start in DONE");
    applyStimulus(8'h5A, 12);
    pulseStart();
    waitStrobes(3, 2000);
    pulseStart();
    checkOutput("busy_after_ignored_start", {31'h0, busy_a}, 1);
    waitDone(2000);
    checkEnd(12, 1'b1);
    applyStimulus(8'h5A, 12);
    pulseStart();
    checkOutput("rerun_busy_valid", {30'h0, busy_a, valid_a}, 32'h2);
    waitDone(2000);
    checkEnd(12, 1'b1);

    $display("[TB] test 6: SPI_DIV=1, NREGS=1");
    use_b = 1'b1;
    mem[1] = 8'h77;
    applyStimulus(8'h5A, 1);
    @(negedge clk28) rst_b_n = 1'b1;
    waitDone(1000);
    checkEnd(1, 1'b1);
    checkOutput("sck_b_period_min", 32'(min_iv), 20);
    checkOutput("sck_b_period_max", 32'(max_iv), 20);
    checkOutput("cs_gap_ge_2clk", {31'h0, (t_busy_b - t_cs_b) >= 20}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
